// File: rtl/vdp_color_mixer.sv
// VDP final pixel stage: background/sprite arbitration, CRAM lookup and the CPU CRAM write port.
// Build option: define VDP_GG_WINDOW_EN to clip the visible window to the Game Gear 160x144 LCD area.
module vdp_color_mixer #(
  parameter int H_ACTIVE = 256,
  parameter int V_ACTIVE = 192
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] pixel_x,
  input  logic [9:0] pixel_y,
  input  logic [5:0] bg_color,
  input  logic       bg_priority,
  input  logic [3:0] spr_color,
  input  logic [3:0] backdrop_idx,
  input  logic       display_en,
  input  logic       cram_we,
  input  logic [5:0] cram_a,
  input  logic [7:0] cram_d,
  output logic [3:0] red,
  output logic [3:0] green,
  output logic [3:0] blue,
  output logic       pixel_active
);

  localparam logic [9:0] H_LIM = 10'(H_ACTIVE);
  localparam logic [9:0] V_LIM = 10'(V_ACTIVE);

  logic [11:0] cram [32];
  logic [7:0]  wr_latch;

  logic        wr_en_p0;
  logic [4:0]  wr_addr_p0;
  logic [11:0] wr_data_p0;

  logic [4:0]  sel_p0;
  logic        vld_p0;
  logic [11:0] rd_p1;
  logic        vld_p1;

  // Byte address bit 0 of the background color is always 0 and carries no information.
  logic unused_bits;
  assign unused_bits = bg_color[0];

  function automatic logic in_window(input logic [9:0] x, input logic [9:0] y);
    logic vis;
    vis = (x < H_LIM) && (y < V_LIM);
`ifdef VDP_GG_WINDOW_EN
    vis = vis && (x >= 10'd48) && (x <= 10'd207) && (y >= 10'd24) && (y <= 10'd167);
`endif
    return vis;
  endfunction

  function automatic logic [4:0] pick_entry(
    input logic       disp,
    input logic [3:0] backdrop,
    input logic [4:0] bg_entry,
    input logic       prio,
    input logic [3:0] spr
  );
    logic [4:0] e;
    if (!disp)
      e = {1'b1, backdrop};
    else if (prio && (bg_entry[3:0] != 4'd0))
      e = bg_entry;
    else if (spr != 4'd0)
      e = {1'b1, spr};
    else
      e = bg_entry;
    return e;
  endfunction

  // Stage p0: pixel selection and window test; CPU byte latch and odd-byte write capture.
  // The captured write commits on the same edge as this pixel's CRAM read, giving read-first.
  always_ff @(posedge clk) begin
    if (rst) begin
      sel_p0   <= 5'd0;
      vld_p0   <= 1'b0;
      wr_latch <= 8'd0;
      wr_en_p0 <= 1'b0;
    end else begin
      sel_p0   <= pick_entry(display_en, backdrop_idx, bg_color[5:1], bg_priority, spr_color);
      vld_p0   <= in_window(pixel_x, pixel_y);
      wr_en_p0 <= cram_we & cram_a[0];
      if (cram_we && !cram_a[0])
        wr_latch <= cram_d;
    end
  end

  always_ff @(posedge clk) begin
    wr_addr_p0 <= cram_a[5:1];
    wr_data_p0 <= {cram_d[3:0], wr_latch};
  end

  always_ff @(posedge clk) begin
    if (wr_en_p0)
      cram[wr_addr_p0] <= wr_data_p0;
  end

  // Stage p1: synchronous CRAM read.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_p1  <= 12'd0;
      vld_p1 <= 1'b0;
    end else begin
      rd_p1  <= cram[sel_p0];
      vld_p1 <= vld_p0;
    end
  end

  // Stage p2: registered RGB, blanked outside the visible window.
  always_ff @(posedge clk) begin
    if (rst || !vld_p1) begin
      red          <= 4'd0;
      green        <= 4'd0;
      blue         <= 4'd0;
      pixel_active <= 1'b0;
    end else begin
      red          <= rd_p1[3:0];
      green        <= rd_p1[7:4];
      blue         <= rd_p1[11:8];
      pixel_active <= 1'b1;
    end
  end

endmodule

// File: tb/tb_vdp_color_mixer.sv
// Scoreboard bench for vdp_color_mixer: directed cases plus random traffic against a behavioural model.
module tb_vdp_color_mixer;

  localparam int H_ACT = 256;
  localparam int V_ACT = 192;
  localparam int LAT   = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic [9:0] pixel_x;
  logic [9:0] pixel_y;
  logic [5:0] bg_color;
  logic       bg_priority;
  logic [3:0] spr_color;
  logic [3:0] backdrop_idx;
  logic       display_en;
  logic       cram_we;
  logic [5:0] cram_a;
  logic [7:0] cram_d;
  logic [3:0] red;
  logic [3:0] green;
  logic [3:0] blue;
  logic       pixel_active;

  vdp_color_mixer #(.H_ACTIVE(H_ACT), .V_ACTIVE(V_ACT)) dut (
    .clk(clk), .rst(rst), .pixel_x(pixel_x), .pixel_y(pixel_y),
    .bg_color(bg_color), .bg_priority(bg_priority), .spr_color(spr_color),
    .backdrop_idx(backdrop_idx), .display_en(display_en),
    .cram_we(cram_we), .cram_a(cram_a), .cram_d(cram_d),
    .red(red), .green(green), .blue(blue), .pixel_active(pixel_active)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad = 0;

  int          due_q[$];
  logic [12:0] val_q[$];
  string       name_q[$];

  logic [11:0] m_cram [32];
  logic [7:0]  m_latch;

  // Expected {active, blue, green, red} straight from the selection rules.
  function automatic logic [12:0] model_pixel();
    int x, y, bgi, idx;
    bit vis;
    x   = int'(pixel_x);
    y   = int'(pixel_y);
    bgi = int'(bg_color) / 2;
    vis = (x < H_ACT) && (y < V_ACT);
`ifdef VDP_GG_WINDOW_EN
    vis = vis && (x >= 48) && (x <= 207) && (y >= 24) && (y <= 167);
`endif
    if (!vis) return 13'd0;
    if (!display_en) idx = 16 + int'(backdrop_idx);
    else if (bg_priority && (bgi % 16) != 0) idx = bgi;
    else if (spr_color != 4'd0) idx = 16 + int'(spr_color);
    else idx = bgi;
    return {1'b1, m_cram[idx]};
  endfunction

  // Record the expectation for the current inputs, update the model, advance one clock.
  task automatic commit(input string nm);
    logic [12:0] v;
    if (rst) begin
      for (int i = 0; i < due_q.size(); i++)
        if (due_q[i] > cyc) val_q[i] = 13'd0;
      v = 13'd0;
      m_latch = 8'd0;
    end else begin
      v = model_pixel();
      if (cram_we) begin
        if (int'(cram_a) % 2 == 0) m_latch = cram_d;
        else m_cram[int'(cram_a) / 2] = {cram_d[3:0], m_latch};
      end
    end
    due_q.push_back(cyc + LAT);
    val_q.push_back(v);
    name_q.push_back(nm);
    @(posedge clk);
    #1;
  endtask

  task automatic set_pix(input int x, input int y, input logic [5:0] bg,
                         input logic pr, input logic [3:0] spr);
    pixel_x = 10'(x);
    pixel_y = 10'(y);
    bg_color = bg;
    bg_priority = pr;
    spr_color = spr;
  endtask

  task automatic pix(input string nm, input int x, input int y, input logic [5:0] bg,
                     input logic pr, input logic [3:0] spr);
    set_pix(x, y, bg, pr, spr);
    commit(nm);
  endtask

  task automatic write_entry(input int idx, input logic [11:0] rgb);
    cram_we = 1'b1;
    cram_a = 6'(idx * 2);
    cram_d = rgb[7:0];
    commit("cram_even");
    cram_a = 6'(idx * 2 + 1);
    cram_d = {4'($urandom_range(0, 15)), rgb[11:8]};
    commit("cram_odd");
    cram_we = 1'b0;
  endtask

  always @(negedge clk) begin
    if (due_q.size() > 0 && due_q[0] <= cyc) begin
      logic [12:0] got;
      got = {pixel_active, blue, green, red};
      total++;
      if (due_q[0] != cyc || got !== val_q[0]) begin
        bad++;
        $display("FAIL %s cyc=%0d due=%0d: got act=%0b bgr=%03h, expected act=%0b bgr=%03h",
                 name_q[0], cyc, due_q[0], got[12], got[11:0], val_q[0][12], val_q[0][11:0]);
      end
      void'(due_q.pop_front());
      void'(val_q.pop_front());
      void'(name_q.pop_front());
    end
  end

  initial begin
    int waited;
    rst = 1'b1;
    cram_we = 1'b0;
    cram_a = 6'd0;
    cram_d = 8'd0;
    display_en = 1'b1;
    backdrop_idx = 4'd0;
    m_latch = 8'd0;
    set_pix(0, 300, 6'd0, 1'b0, 4'd0);
    @(posedge clk);
    #1;
    repeat (3) commit("reset_state");
    rst = 1'b0;

    for (int i = 0; i < 32; i++) write_entry(i, 12'($urandom));
    write_entry(0, 12'h123);

    // Direct byte writes: 0x5A then 0x0C -> entry 2 = B:C G:5 R:A.
    cram_we = 1'b1;
    cram_a = 6'h04; cram_d = 8'h5A; commit("wr_even");
    cram_a = 6'h05; cram_d = 8'h0C; commit("wr_odd");
    cram_we = 1'b0;
    pix("cram_rgb", 100, 100, 6'h04, 1'b0, 4'd0);

    write_entry(3, 12'h111);
    write_entry(21, 12'h222);
    pix("prio_spr", 100, 100, 6'h06, 1'b0, 4'd5);
    pix("prio_bg", 100, 100, 6'h06, 1'b1, 4'd5);
    pix("prio_bg_idx0", 100, 100, 6'h00, 1'b1, 4'd5);
    pix("bg_idx0_own", 100, 100, 6'h20, 1'b0, 4'd0);

    write_entry(18, 12'hF0F);
    display_en = 1'b0;
    backdrop_idx = 4'd2;
    for (int i = 0; i < 6; i++)
      pix("backdrop", 60 + i * 20, 50 + i * 10, 6'($urandom), 1'($urandom), 4'($urandom));
    pix("backdrop_blank", 100, 200, 6'h06, 1'b0, 4'd5);
    display_en = 1'b1;

    pix("win_x255", 255, 100, 6'h04, 1'b0, 4'd0);
    pix("win_x256", 256, 100, 6'h04, 1'b0, 4'd0);
    pix("win_y192", 100, 192, 6'h04, 1'b0, 4'd0);
    pix("win_y191", 100, 191, 6'h04, 1'b0, 4'd0);
    pix("gg_x47", 47, 100, 6'h04, 1'b0, 4'd0);
    pix("gg_x48", 48, 100, 6'h04, 1'b0, 4'd0);
    pix("gg_x207", 207, 100, 6'h04, 1'b0, 4'd0);
    pix("gg_x208", 208, 100, 6'h04, 1'b0, 4'd0);
    pix("gg_y23", 100, 23, 6'h04, 1'b0, 4'd0);
    pix("gg_y24", 100, 24, 6'h04, 1'b0, 4'd0);
    pix("gg_y167", 100, 167, 6'h04, 1'b0, 4'd0);
    pix("gg_y168", 100, 168, 6'h04, 1'b0, 4'd0);

    // Entry 7 on screen continuously while it is rewritten.
    set_pix(120, 80, 6'h0E, 1'b0, 4'd0);
    write_entry(7, 12'h345);
    commit("rf_pre");
    cram_we = 1'b1;
    cram_a = 6'h0E; cram_d = 8'h9A; commit("rf_even");
    cram_a = 6'h0F; cram_d = 8'hFB; commit("rf_write_cycle");
    cram_we = 1'b0;
    commit("rf_next");
    commit("rf_next2");

    // Mid-frame reset after an even write; the strobe during reset is dropped.
    set_pix(130, 90, 6'h00, 1'b0, 4'd0);
    commit("rs_pre");
    cram_we = 1'b1;
    cram_a = 6'h00; cram_d = 8'hFF; commit("rs_even");
    rst = 1'b1;
    cram_a = 6'h03; cram_d = 8'h0F; commit("rs_reset");
    rst = 1'b0;
    cram_a = 6'h01; cram_d = 8'h00; commit("rs_odd");
    cram_we = 1'b0;
    commit("rs_post1");
    commit("rs_entry0");
    pix("rs_entry1", 130, 90, 6'h02, 1'b0, 4'd0);

    for (int i = 0; i < 600; i++) begin
      rst = ($urandom_range(0, 99) == 0);
      pixel_x = 10'($urandom_range(0, 300));
      pixel_y = 10'($urandom_range(0, 220));
      bg_color = 6'($urandom);
      bg_priority = 1'($urandom);
      spr_color = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom);
      backdrop_idx = 4'($urandom);
      display_en = ($urandom_range(0, 7) != 0);
      cram_we = ($urandom_range(0, 3) == 0);
      cram_a = 6'($urandom);
      cram_d = 8'($urandom);
      commit("random");
    end

    rst = 1'b0;
    cram_we = 1'b0;
    waited = 0;
    while (due_q.size() > 0 && waited < 10) begin
      @(posedge clk);
      waited++;
    end
    #1;
    if (due_q.size() > 0) begin
      total++;
      bad++;
      $display("FAIL drain: %0d expectations left unchecked, required 0", due_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vdp_color_mixer.md
# vdp_color_mixer

Final pixel stage of the VDP, directly downstream of the background renderer and the sprite engine. Each pixel clock it arbitrates the background color/priority against the sprite pixel and looks the winner up in the 32-entry, 12-bit color RAM (CRAM). It emits 4:4:4 RGB plus an active flag to the video output. It also owns the CPU-side CRAM write port, including the Game Gear two-byte write latch.

## Interface
Parameters:
- `H_ACTIVE`, 256: active pixels per line in VDP coordinates.
- `V_ACTIVE`, 192: active lines per frame.

Ports:
- `clk`  in  1  pixel clock, same as the background renderer.
- `rst`  in  1  synchronous, active-high reset.
- `pixel_x`  in  10  current pixel column, the same counter that drives the background renderer.
- `pixel_y`  in  10  current line.
- `bg_color`  in  6  background CRAM byte address: bit0=0, [4:1] index, [5] palette.
- `bg_priority`  in  1  background tile has priority over sprites.
- `spr_color`  in  4  sprite pixel index into the upper palette; 0 means transparent.
- `backdrop_idx`  in  4  backdrop index into the upper palette (VDP reg 7 [3:0]).
- `display_en`  in  1  display enable (VDP reg 1 bit 6).
- `cram_we`  in  1  CPU write strobe, one cycle per byte.
- `cram_a`  in  6  CPU CRAM byte address.
- `cram_d`  in  8  CPU write data.
- `red`, `green`, `blue`  out  4 each  pixel color.
- `pixel_active`  out  1  the output pixel lies inside the visible window.

## Operation
- CRAM storage: 32 entries × 12 bits, stored as `{blue, green, red}`. Contents are not cleared by reset.
- CPU write rule:
  - Write to an even address: latch `cram_d` into `wr_latch`. CRAM is unchanged.
  - Write to an odd address: write entry `cram_a[5:1]` with `{cram_d[3:0], wr_latch[7:4], wr_latch[3:0]}`, i.e. blue, green, red.
  - Even byte format is GGGGRRRR. Odd byte bits [7:4] are ignored.
- Pixel selection, evaluated in stage 1 in priority order. The first matching rule sets the 5-bit entry `sel`:
  1. Pixel outside the visible window: forced black, `sel` is don't-care.
  2. `display_en`=0: `sel` = {1, `backdrop_idx`}.
  3. `bg_priority`=1 and `bg_color[4:1]`≠0: `sel` = `bg_color[5:1]`.
  4. `spr_color`≠0: `sel` = {1, `spr_color`}.
  5. Otherwise: `sel` = `bg_color[5:1]`. Background index 0 shows its own palette entry, not the backdrop.
- Visible window: `pixel_x` < `H_ACTIVE` and `pixel_y` < `V_ACTIVE`, further restricted by the configuration below.

## Timing
- Pipeline:
  - Stage 1 registers `sel` and `vis`.
  - Stage 2 is a synchronous CRAM read.
  - Stage 3 registers the RGB outputs.
- Latency: inputs sampled at edge N appear on `red`/`green`/`blue`/`pixel_active` after edge N+2. Output is 1 pixel per clock with no stalls.
- When `vis`=0, RGB = 0 and `pixel_active`=0, both at the same latency.
- A CPU write and a pixel read of the same entry in the same cycle is read-first: the pixel gets the old value and the new value is visible on the next cycle.
- An even and an odd write are independent strobes and need not be consecutive. A second even write overwrites `wr_latch`. An odd write without a preceding even write uses the current `wr_latch`.
- Reset (asserted at any time, including mid-frame):
  - `wr_latch`, all pipeline registers, `red`/`green`/`blue` and `pixel_active` go to 0 on the next edge.
  - The first valid pixel appears 2 cycles after reset is released.
  - A CPU write strobe coincident with `rst` is dropped.
- `pixel_x`/`pixel_y` wrap-around needs no special handling. Values ≥ `H_ACTIVE`/`V_ACTIVE` are simply invisible.

## Configuration
- `VDP_GG_WINDOW_EN` defined: the visible window is further restricted to the Game Gear LCD area, x 48..207 and y 24..167 inclusive (160×144). Pixels outside that area but inside 256×192 output black with `pixel_active`=0.
- `VDP_GG_WINDOW_EN` undefined: the full `H_ACTIVE`×`V_ACTIVE` area is visible, as on SMS.

## Test plan
- CRAM write:
  - Stimulus: write 0x5A to address 0x04, then 0x0C to address 0x05. Drive `bg_color`=0x04 and `bg_priority`=0 with `spr_color`=0, at pixel (100,100).
  - Required response 2 cycles later: red=0xA, green=0x5, blue=0xC, `pixel_active`=1.
- Priority:
  - Setup: entry 3 = 0x111, entry 21 = 0x222.
  - `bg_color`=0x06, `spr_color`=5, `bg_priority`=0 → 0x222.
  - Same with `bg_priority`=1 → 0x111.
  - `bg_color`=0x00, `bg_priority`=1, `spr_color`=5 → 0x222.
- Backdrop:
  - Stimulus: `display_en`=0, `backdrop_idx`=2, entry 18 = 0xF0F.
  - Required response: every visible pixel outputs red=F, green=0, blue=F regardless of `bg_color`/`spr_color`.
- Window and blanking:
  - `pixel_x`=255 → pixel visible when `VDP_GG_WINDOW_EN` is undefined, RGB 0 with `pixel_active`=0 when it is defined.
  - `pixel_y`=192 → RGB 0 and `pixel_active`=0 in both builds.
  - Both checked at latency 2.
- Read-first collision:
  - Stimulus: display entry 7 continuously while an odd write to address 0x0F updates it.
  - Required response: the pixel sampled in the write cycle shows the old value; the next pixel shows the new value.
- Reset mid-frame:
  - Stimulus: assert `rst` for 1 cycle during active video after an even write of 0xFF.
  - Required response: outputs are 0 on the next edge. A following odd write of 0x00 to address 0x01 stores entry 0 = 0x000, which confirms the latch was cleared.
